// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory-stage SRAM controller: FSM encoding, default
// CPU base address of the SRAM window and the external SRAM data width.
package memory_stage_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int unsigned DEFAULT_BASE_ADDRESS = 1024;
    localparam int unsigned SRAM_DW              = 16;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-halfword hold counter: counts 0..WAIT_CYCLES-1 while enabled, clears on demand.
// tc_o flags the last hold cycle combinationally from the registered count; no backpressure.
module sram_wait_counter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/memory_stage_sram_controller.sv
// 32-bit load/store over a 16-bit SRAM as two halfword accesses; ready=1 at cycle 2*WAIT_CYCLES+1,
// ready=0 freezes the pipeline meanwhile. SRAM_LAST_READ_BUFFER_EN adds a one-entry last-read hit buffer.
module memory_stage_sram_controller
    import memory_stage_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 18,
    parameter int unsigned BASE_ADDRESS = DEFAULT_BASE_ADDRESS,
    parameter int unsigned WAIT_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memoryReadEnabled,
    input  logic                  memoryWriteEnabled,
    input  logic [31:0]           aluResult,
    input  logic [31:0]           valRm,
    output logic [31:0]           readData,
    output logic                  ready,
    output logic [ADDR_WIDTH-1:0] sramAddress,
    output logic [SRAM_DW-1:0]    sramWriteData,
    input  logic [SRAM_DW-1:0]    sramReadData,
    output logic                  sramWeN
);

    logic [1:0]            state_q, state_d;
    logic                  wr_q, wr_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [ADDR_WIDTH-2:0] word_addr;
    logic                  req, hit, tc, in_access;

    assign word_addr = (ADDR_WIDTH-1)'((aluResult - BASE_ADDRESS) >> 2);
    assign req       = memoryReadEnabled | memoryWriteEnabled;
    assign in_access = (state_q == ST_LO) || (state_q == ST_HI);

    sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q != state_d),
        .en_i  (in_access),
        .tc_o  (tc)
    );

    // The write flag is latched so a request dropping mid-access still completes the same operation.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: if (req && !hit) begin
                state_d = ST_LO;
                wr_d    = memoryWriteEnabled;
            end
            ST_LO: if (tc) begin
                state_d = ST_HI;
                if (!wr_q) rdata_d[15:0] = sramReadData;
            end
            ST_HI: if (tc) begin
                state_d = ST_DONE;
                if (!wr_q) rdata_d[31:16] = sramReadData;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        sramAddress   = '0;
        sramWriteData = '0;
        sramWeN       = 1'b1;
        if (state_q == ST_LO) begin
            sramAddress   = {word_addr, 1'b0};
            sramWriteData = valRm[15:0];
            sramWeN       = ~wr_q;
        end else if (state_q == ST_HI) begin
            sramAddress   = {word_addr, 1'b1};
            sramWriteData = valRm[31:16];
            sramWeN       = ~wr_q;
        end
    end

    assign ready = ~req | (state_q == ST_DONE) | hit;

`ifdef SRAM_LAST_READ_BUFFER_EN
    logic                  buf_vld_q, buf_vld_d;
    logic [ADDR_WIDTH-2:0] buf_tag_q, buf_tag_d;
    logic [31:0]           buf_dat_q, buf_dat_d;

    // Read-and-write together is a write, so it never hits.
    assign hit = (state_q == ST_IDLE) && memoryReadEnabled && !memoryWriteEnabled
              && buf_vld_q && (buf_tag_q == word_addr);

    always_comb begin
        buf_vld_d = buf_vld_q;
        buf_tag_d = buf_tag_q;
        buf_dat_d = buf_dat_q;
        if (state_q == ST_HI && tc && !wr_q) begin
            buf_vld_d = 1'b1;
            buf_tag_d = word_addr;
            buf_dat_d = {sramReadData, rdata_q[15:0]};
        end else if (state_q == ST_DONE && wr_q && buf_tag_q == word_addr) begin
            buf_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_vld_q <= 1'b0;
            buf_tag_q <= '0;
            buf_dat_q <= '0;
        end else begin
            buf_vld_q <= buf_vld_d;
            buf_tag_q <= buf_tag_d;
            buf_dat_q <= buf_dat_d;
        end
    end

    assign readData = hit ? buf_dat_q : rdata_q;
`else
    assign hit      = 1'b0;
    assign readData = rdata_q;
`endif

endmodule

// File: tb/tb_memory_stage_sram_controller.sv
// Directed bench for memory_stage_sram_controller with a behavioural 16-bit SRAM;
// per-cycle address/data/enable/ready expectations are derived from the request and WAIT_CYCLES.
module tb_memory_stage_sram_controller;

    localparam int W  = 2;
    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          memoryReadEnabled = 1'b0;
    logic          memoryWriteEnabled = 1'b0;
    logic [31:0]   aluResult = '0;
    logic [31:0]   valRm = '0;
    logic [31:0]   readData;
    logic          ready;
    logic [AW-1:0] sramAddress;
    logic [15:0]   sramWriteData;
    logic [15:0]   sramReadData;
    logic          sramWeN;

    logic [15:0] mem [0:255];

    int vectors = 0;
    int miscompares = 0;

    memory_stage_sram_controller #(
        .ADDR_WIDTH   (AW),
        .BASE_ADDRESS (1024),
        .WAIT_CYCLES  (W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .memoryReadEnabled  (memoryReadEnabled),
        .memoryWriteEnabled (memoryWriteEnabled),
        .aluResult          (aluResult),
        .valRm              (valRm),
        .readData           (readData),
        .ready              (ready),
        .sramAddress        (sramAddress),
        .sramWriteData      (sramWriteData),
        .sramReadData       (sramReadData),
        .sramWeN            (sramWeN)
    );

    always #5 clk = ~clk;

    assign sramReadData = mem[sramAddress[7:0]];
    always @(posedge clk) begin
        if (!sramWeN) mem[sramAddress[7:0]] <= sramWriteData;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Applies one request at #1 after an edge and checks every cycle up to the one with ready=1.
    // Returns #1 after the edge that ends the ready cycle, request still driven.
    task automatic run_op(input string tag, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d, input logic hit,
                          input logic chk_rd, input logic [31:0] exp_rd);
        logic [16:0] wa;
        logic [31:0] ea, ewd;
        logic        ewe, erdy;
        int          last;
        wa   = 17'((a - 32'd1024) >> 2);
        last = hit ? 0 : 2 * W + 1;
        memoryReadEnabled  = rd;
        memoryWriteEnabled = wr;
        aluResult          = a;
        valRm              = d;
        for (int n = 0; n <= last; n++) begin
            @(negedge clk);
            ea = 0; ewd = 0; ewe = 1'b1; erdy = (n == last);
            if (n >= 1 && n <= W) begin
                ea = {15'd0, wa, 1'b0}; ewd = {16'd0, d[15:0]}; ewe = ~wr;
            end else if (n > W && n <= 2 * W) begin
                ea = {15'd0, wa, 1'b1}; ewd = {16'd0, d[31:16]}; ewe = ~wr;
            end
            chk({tag, ".ready"}, {31'd0, ready}, {31'd0, erdy});
            chk({tag, ".addr"},  {14'd0, sramAddress}, ea);
            chk({tag, ".wdata"}, {16'd0, sramWriteData}, ewd);
            chk({tag, ".wen"},   {31'd0, sramWeN}, {31'd0, ewe});
            if (n == last && chk_rd) chk({tag, ".rdata"}, readData, exp_rd);
            @(posedge clk); #1;
        end
    endtask

    task automatic idle_req();
        memoryReadEnabled  = 1'b0;
        memoryWriteEnabled = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state and idle behaviour
        chk("reset.rdata", readData, 32'h0);
        chk("reset.wdata", {16'd0, sramWriteData}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle.ready", {31'd0, ready}, 32'd1);
            chk("idle.wen",   {31'd0, sramWeN}, 32'd1);
            chk("idle.addr",  {14'd0, sramAddress}, 32'd0);
        end
        @(posedge clk); #1;

        // Stores, then back-to-back loads
        run_op("st1028", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        run_op("st1032", 1'b0, 1'b1, 32'd1032, 32'h22221111, 1'b0, 1'b0, 32'h0);
        run_op("st1036", 1'b0, 1'b1, 32'd1036, 32'h00000000, 1'b0, 1'b0, 32'h0);
        idle_req();
        @(posedge clk); #1;
        chk("mem2", {16'd0, mem[2]}, 32'h0000BEEF);
        chk("mem3", {16'd0, mem[3]}, 32'h0000DEAD);
        run_op("ld1028", 1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        run_op("ld1032", 1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, 1'b1, 32'h22221111);
        idle_req();
        @(posedge clk); #1;

        // Read and write together: write wins, readData untouched
        run_op("rdwr", 1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0, 1'b1, 32'h22221111);
        idle_req();
        @(posedge clk); #1;
        chk("mem0", {16'd0, mem[0]}, 32'h00005678);
        chk("mem1", {16'd0, mem[1]}, 32'h00001234);

        // Reset during the high halfword of a store
        memoryWriteEnabled = 1'b1;
        aluResult          = 32'd1036;
        valRm              = 32'hAAAA5555;
        repeat (3) @(posedge clk);
        #2;
        chk("midhi.addr", {14'd0, sramAddress}, 32'd7);
        chk("midhi.wen",  {31'd0, sramWeN}, 32'd0);
        rst = 1'b1;
        #1;
        chk("arst.addr",  {14'd0, sramAddress}, 32'd0);
        chk("arst.wen",   {31'd0, sramWeN}, 32'd1);
        chk("arst.wdata", {16'd0, sramWriteData}, 32'd0);
        chk("arst.rdata", readData, 32'd0);
        idle_req();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("arst.mem6", {16'd0, mem[6]}, 32'h00005555);
        chk("arst.mem7", {16'd0, mem[7]}, 32'h00000000);
        run_op("post_st", 1'b0, 1'b1, 32'd1036, 32'h0BADF00D, 1'b0, 1'b0, 32'h0);
        idle_req();
        @(posedge clk); #1;
        chk("post.mem7", {16'd0, mem[7]}, 32'h00000BAD);
        run_op("post_ld", 1'b1, 1'b0, 32'd1036, 32'h0, 1'b0, 1'b1, 32'h0BADF00D);
        idle_req();
        @(posedge clk); #1;

`ifdef SRAM_LAST_READ_BUFFER_EN
        run_op("buf_miss", 1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        run_op("buf_hit",  1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF);
        @(negedge clk);
        chk("buf_hit.noacc", {14'd0, sramAddress}, 32'd0);
        idle_req();
        @(posedge clk); #1;
        run_op("buf_st", 1'b0, 1'b1, 32'd1028, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0);
        idle_req();
        @(posedge clk); #1;
        run_op("buf_inval", 1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D);
        idle_req();
        @(posedge clk); #1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
